rle_token_unpacker: RTL and testbench
=====================================

// Module: rle_token_unpacker
// PURPOSE
//  Upstream stage of the IO-module run-length decompressor.
//  Pulls packed N-bit compressed words from the memory manager and slices out fixed-width
//  tokens {bit, run_length}, LSB-first. Tokens may straddle word boundaries.
//  Each token is presented on a valid/ready port that drives the decompressor's bit/value/start inputs.
// PARAMETERS
//  N    32                   compressed word width; equals decompressor word width
//  LW   $clog2(N)+1          run-length field width; matches decompressor 'value'
//  TW   LW+1                 token width; token = {bit[TW-1], len[LW-1:0]}
//  CW   16                   width of token-count field
// PORTS
//  clk         in   1     single clock, rising edge
//  reset       in   1     asynchronous, active-low reset
//  start       in   1     pulse: begin a stream; sampled only in IDLE
//  num_tokens  in   CW    tokens in the stream; latched on accepted start
//  word_in     in   N     packed compressed word
//  word_valid  in   1     word_in valid
//  word_ready  out  1     unpacker accepts word_in this cycle
//  tok_valid   out  1     token available
//  tok_bit     out  1     run bit value (to decompressor 'bit')
//  tok_len     out  LW    run length (to decompressor 'value')
//  tok_ready   in   1     consumer takes the token this cycle
//  busy        out  1     state != IDLE
//  done        out  1     one-cycle pulse when the last token has been consumed
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, buffer=0, fill=0, remaining=0.
//   All outputs 0: word_ready, tok_valid, tok_bit, tok_len, busy, done.
//  State buffer: buf[2N-1:0] plus fill count [$clog2(2N):0]. The next token is always buf[TW-1:0].
//  FSM: IDLE -> RUN on start (num_tokens!=0); remaining<=num_tokens, fill<=0.
//   IDLE -> DONE on start with num_tokens==0.
//   RUN -> DONE in the cycle remaining reaches 0. DONE -> IDLE after 1 cycle; done=1 only in DONE.
//   start is ignored outside IDLE.
//  word_ready = (state==RUN) & (fill<TW) & (remaining!=0). Fetch only what is needed.
//  Word accept (word_valid&word_ready): word_in is written at bit position fill' and fill' += N.
//   fill' is fill after any same-cycle pop.
//  tok_valid = (state==RUN) & (fill>=TW) & (tok_len!=0). tok_bit/tok_len come combinationally from buf.
//  Pop: when fill>=TW in RUN, and either tok_len==0 (dropped silently, 1 cycle) or tok_valid&tok_ready.
//   Effect: buf >>= TW, fill -= TW, remaining -= 1.
//  Simultaneous pop and word accept in one cycle is legal; the shift is applied before the append.
//  Latency: word accepted at cycle k -> first token valid at k+1.
//   Back-to-back tokens at 1/cycle while fill>=TW.
//  tok_valid held and tok_bit/tok_len stable until tok_ready. tok_len>N is passed unchanged
//   (the decompressor spans words).
//  On entering DONE, leftover buffer bits (padding) are discarded: fill<=0.
//  word_valid while word_ready=0 has no effect. No word is ever fetched after the last token is popped.
//  Reset mid-stream aborts immediately; a partial word or token is lost and no done pulse is produced.
// STRUCTURE
//  Shared package rle_pkg: LW/TW derivation functions, token field offsets, FSM state
//   encoding (IDLE=0, RUN=1, DONE=2). Used by both the decompressor and this unpacker.
//  One sub-module: rle_bit_buffer holds buf and fill, with push(N)/pop(TW) and level output.
//   The FSM and remaining counter live in the top module.
// TESTING (N=32, TW=7)
//  1) reset=0 mid-RUN -> all outputs 0 at once; next start runs cleanly from an empty buffer.
//  2) start, num_tokens=2, word 0x00000DC5 -> tokens (1,5) then (0,27); done 1 cycle after 2nd pop;
//     exactly one word fetched.
//  3) num_tokens=5 (35 bits) -> 2 words fetched; 5th token straddles bits 28..34.
//     Verify its value and that the upper 29 bits of word 2 are discarded.
//  4) tok_ready=0 for 10 cycles -> tok_bit/tok_len stable, no extra word fetched, remaining unchanged.
//  5) Token with len=0 between (1,3) and (0,4) -> consumer sees only two tokens; done after 3 pops.
//  6) start with num_tokens=0 -> done pulse next cycle, word_ready never 1.
//     start asserted during RUN -> ignored.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length unpacker/decompressor pair: field widths,
// token layout and the FSM state encoding.
package rle_pkg;

    localparam int N_DEFAULT  = 32;
    localparam int CW_DEFAULT = 16;

    // Run-length field must be able to hold the value N itself.
    function automatic int calc_lw(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int calc_tw(input int n);
        return calc_lw(n) + 1;
    endfunction

    // Token layout: {bit, len}; len sits at the bottom, the run bit directly above it.
    localparam int TOK_LEN_LSB = 0;

    function automatic int tok_bit_pos(input int n);
        return calc_lw(n);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rle_state_e;

endpackage

// File: rtl/rle_bit_buffer.sv
// Two-word bit FIFO: words are appended above the current fill level and tokens are
// shifted out of the bottom, so the next token always sits at bits [TW-1:0].
module rle_bit_buffer #(
    parameter int N  = 32,
    parameter int TW = 7,
    parameter int FW = $clog2(2 * N) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [N-1:0]  word_in,
    output logic [TW-1:0] head,
    output logic [FW-1:0] level
);

    logic [2*N-1:0] bits_q, bits_d, bits_shifted;
    logic [FW-1:0]  fill_q, fill_d, fill_shifted;

    // Pop is applied first so an appended word lands right after the surviving bits.
    always_comb begin
        bits_shifted = pop ? (bits_q >> TW) : bits_q;
        fill_shifted = pop ? (fill_q - FW'(TW)) : fill_q;
        bits_d       = bits_shifted;
        fill_d       = fill_shifted;
        if (push) begin
            bits_d = bits_shifted | ({{N{1'b0}}, word_in} << fill_shifted);
            fill_d = fill_shifted + FW'(N);
        end
        if (clear) begin
            bits_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bits_q <= '0;
            fill_q <= '0;
        end else begin
            bits_q <= bits_d;
            fill_q <= fill_d;
        end
    end

    assign head  = bits_q[TW-1:0];
    assign level = fill_q;

endmodule

// File: rtl/rle_token_unpacker.sv
// Slices {bit, run_length} tokens LSB-first out of packed compressed words and hands
// them to the decompressor over a valid/ready port.
module rle_token_unpacker
    import rle_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int CW = CW_DEFAULT,
    parameter int LW = calc_lw(N),
    parameter int TW = LW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] num_tokens,
    input  logic [N-1:0]  word_in,
    input  logic          word_valid,
    output logic          word_ready,
    output logic          tok_valid,
    output logic          tok_bit,
    output logic [LW-1:0] tok_len,
    input  logic          tok_ready,
    output logic          busy,
    output logic          done,
    output rle_state_e    state_dbg
);

    localparam int FW = $clog2(2 * N) + 1;

    // Handshakes: a word moves when word_valid & word_ready at a rising edge; a token
    // moves when tok_valid & tok_ready. Neither valid depends on its ready, and an
    // offered token stays stable until taken.

    rle_state_e    state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [TW-1:0] head;
    logic [FW-1:0] level;
    logic          in_run, has_tok, pop, push, clear;

    rle_bit_buffer #(.N(N), .TW(TW), .FW(FW)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .word_in (word_in),
        .head    (head),
        .level   (level)
    );

    assign in_run     = (state_q == ST_RUN);
    assign has_tok    = (level >= FW'(TW));
    assign tok_len    = head[TOK_LEN_LSB +: LW];
    assign tok_bit    = head[tok_bit_pos(N)];
    assign word_ready = in_run && !has_tok && (remaining_q != '0);
    assign tok_valid  = in_run && has_tok && (tok_len != '0);
    // Zero-length tokens carry no run and are consumed without a handshake.
    assign pop        = in_run && has_tok && ((tok_len == '0) || tok_ready);
    assign push       = word_valid && word_ready;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign state_dbg  = state_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        clear       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = num_tokens;
                    clear       = 1'b1;
                    state_d     = (num_tokens == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop) begin
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = ST_DONE;
                        clear   = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_rle_token_unpacker.sv
// Directed bench for rle_token_unpacker (N=32, TW=7): a vector table of whole streams
// plus hand-written sequences for reset abort and back-pressure.
module tb_rle_token_unpacker;
    import rle_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_tokens = '0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        tok_valid;
    logic        tok_bit;
    logic [5:0]  tok_len;
    logic        tok_ready = 1'b0;
    logic        busy;
    logic        done;
    rle_state_e  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    rle_token_unpacker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_tokens (num_tokens),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tok_valid  (tok_valid),
        .tok_bit    (tok_bit),
        .tok_len    (tok_len),
        .tok_ready  (tok_ready),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     ntok;
        int              nwords;
        logic [31:0]     w0;
        logic [31:0]     w1;
        int              exp_fetch;
        int              nexp;
        logic [4:0][6:0] exp_tok;
        bit              slow;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int seen = 0, fetched = 0, word_idx = 0;
        int last_evt = 0, done_cyc = -1, first_valid = -1, first_fetch = -1;
        @(negedge clk);
        start = 1'b1;
        num_tokens = v.ntok;
        word_valid = 1'b0;
        tok_ready = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            word_valid = (word_idx < v.nwords);
            word_in = (word_idx == 0) ? v.w0 : v.w1;
            tok_ready = v.slow ? cyc[0] : 1'b1;
            #1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (word_valid && word_ready) begin
                if (first_fetch < 0) first_fetch = cyc;
                fetched++;
                word_idx++;
            end
            if (tok_valid && first_valid < 0) first_valid = cyc;
            if (tok_valid && tok_ready) begin
                if (seen < v.nexp)
                    check($sformatf("v%0d_tok%0d", id, seen), 32'({tok_bit, tok_len}), 32'(v.exp_tok[seen]));
                seen++;
                last_evt = cyc;
            end
        end
        check($sformatf("v%0d_done_timing", id), done_cyc, last_evt + 1);
        check($sformatf("v%0d_tok_count", id), seen, v.nexp);
        check($sformatf("v%0d_fetch_count", id), fetched, v.exp_fetch);
        if (v.nexp > 0)
            check($sformatf("v%0d_latency", id), first_valid - first_fetch, 1);
        @(negedge clk);
        word_valid = 1'b0;
        tok_ready = 1'b0;
        #1;
        check($sformatf("v%0d_back_idle", id), {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        // A: two tokens in one word; B: five tokens, the last straddling two words
        // with junk above it; C: a zero-length token in the middle; D: empty stream;
        // E: B again under alternating back-pressure.
        vecs[0] = '{ntok: 16'd2, nwords: 1, w0: 32'h0000_0DC5, w1: 32'h0, exp_fetch: 1,
                    nexp: 2, exp_tok: {7'h0, 7'h0, 7'h0, 7'h1B, 7'h45}, slow: 1'b0};
        vecs[1] = '{ntok: 16'd5, nwords: 2, w0: 32'h1158_0243, w1: 32'hFFFF_FFFE, exp_fetch: 2,
                    nexp: 5, exp_tok: {7'h61, 7'h0A, 7'h60, 7'h04, 7'h43}, slow: 1'b0};
        vecs[2] = '{ntok: 16'd3, nwords: 1, w0: 32'h0001_2043, w1: 32'h0, exp_fetch: 1,
                    nexp: 2, exp_tok: {7'h0, 7'h0, 7'h0, 7'h04, 7'h43}, slow: 1'b0};
        vecs[3] = '{ntok: 16'd0, nwords: 1, w0: 32'hDEAD_BEEF, w1: 32'h0, exp_fetch: 0,
                    nexp: 0, exp_tok: '0, slow: 1'b0};
        vecs[4] = '{ntok: 16'd5, nwords: 2, w0: 32'h1158_0243, w1: 32'hFFFF_FFFE, exp_fetch: 2,
                    nexp: 5, exp_tok: {7'h61, 7'h0A, 7'h60, 7'h04, 7'h43}, slow: 1'b1};

        #12;
        check("reset_outputs", {24'd0, word_ready, tok_valid, tok_bit, tok_len[4:0]}, 32'd0);
        check("reset_misc", {24'd0, tok_len[5], busy, done, 3'd0, state_dbg}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Abort mid-stream: one word fetched and one token taken, then reset.
        @(negedge clk);
        start = 1'b1;
        num_tokens = 16'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        word_valid = 1'b1;
        word_in = vecs[1].w0;
        tok_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        word_valid = 1'b0;
        #1;
        check("midrun_tok", {23'd0, tok_valid, tok_bit, tok_len}, {23'd0, 1'b1, 7'h43});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_outputs", {22'd0, word_ready, tok_valid, tok_bit, tok_len, busy, done},
              32'd0);
        @(negedge clk);
        reset = 1'b1;
        tok_ready = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Back-pressure: hold the first token 10 cycles while a second word is offered
        // and a restart is attempted; the original two tokens must still follow.
        @(negedge clk);
        start = 1'b1;
        num_tokens = 16'd2;
        tok_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        word_valid = 1'b1;
        word_in = 32'h0000_0DC5;
        @(posedge clk);
        @(negedge clk);
        word_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            start = (i == 3);
            num_tokens = 16'd7;
            #1;
            check($sformatf("hold%0d", i), {21'd0, tok_valid, word_ready, busy, tok_bit, tok_len},
                  {21'd0, 1'b1, 1'b0, 1'b1, 7'h45});
            @(negedge clk);
        end
        start = 1'b0;
        tok_ready = 1'b1;
        #1;
        check("release_tok0", {23'd0, tok_valid, tok_bit, tok_len}, {23'd0, 1'b1, 7'h45});
        @(negedge clk);
        #1;
        check("release_tok1", {22'd0, word_ready, tok_valid, tok_bit, tok_len},
              {22'd0, 1'b0, 1'b1, 7'h1B});
        @(negedge clk);
        #1;
        check("release_done", {29'd0, word_ready, busy, done}, {29'd0, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        word_valid = 1'b0;
        tok_ready = 1'b0;
        #1;
        check("release_idle", {30'd0, busy, done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
